// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants and the transmitter FSM states,
// kept here so a future receiver can reuse them.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: free-running modulo-CLKS_PER_BIT counter with a registered
// strobe that is high during the last cycle of each bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned     CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_end_d;

  // Strobe is computed from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    bit_end_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: valid/ready byte intake, start bit, LSB-first
// data, optional parity, one or two stop bits; registered serial output.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY > PARITY_EVEN) || ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam int unsigned IDX_W   = 4;
  localparam bit          HAS_PAR = (PARITY != PARITY_NONE);

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 hs_c;
  logic                 bit_end;

  assign hs_c = tx_valid && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(hs_c),
    .bit_end(bit_end)
  );

  // Next-state and next-output logic; tx only moves at a bit boundary or on capture.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    par_d   = par_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (hs_c) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ (PARITY == PARITY_ODD);
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              idx_d   = '0;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over a coincident handshake, dropping the offered data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule
